// File: rtl/cdb_writeback_pkg.sv
// cdb_writeback_pkg: shared widths, register-file size and label constants for the CDB writeback block.
// Contents: LABEL_W, DATA_W, NUM_REGS, REG_AW, label_t/data_t/reg_addr_t types, LABEL_NONE,
// and label_at/value_at slice helpers for the packed per-FU vectors.
// Optional feature macro used by the design: CDB_BYPASS_EN.
package cdb_writeback_pkg;
    localparam int LABEL_W  = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    typedef logic [LABEL_W-1:0] label_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [REG_AW-1:0]  reg_addr_t;
    localparam label_t LABEL_NONE = '0;
    // Helpers work on an 8-FU wide container so any N_FU in 2..8 can share them.
    function automatic label_t label_at(input logic [8*LABEL_W-1:0] v, input int i);
        return v[i*LABEL_W +: LABEL_W];
    endfunction
    function automatic data_t value_at(input logic [8*DATA_W-1:0] v, input int i);
        return v[i*DATA_W +: DATA_W];
    endfunction
endpackage

// File: rtl/cdb_writeback_if.sv
// cdb_writeback_if: FU result bus, CDB broadcast and issue-stage read/label-write signals.
// slave modport: the writeback block (consumes FU results, issue writes and read addresses;
//   drives fu_ready, the CDB broadcast and the read data).
// master modport: the surrounding pipeline (FUs + issue stage).
interface cdb_writeback_if
    import cdb_writeback_pkg::*;
#(
    parameter int N_FU = 4
);
    logic [N_FU-1:0]         fu_valid;
    logic [N_FU*LABEL_W-1:0] fu_label;
    logic [N_FU*DATA_W-1:0]  fu_value;
    logic [N_FU-1:0]         fu_ready;
    logic                    cdb_valid;
    label_t                  cdb_label;
    data_t                   cdb_value;
    reg_addr_t               readAddr1;
    reg_addr_t               readAddr2;
    label_t                  labelOut1;
    label_t                  labelOut2;
    data_t                   dataOut1;
    data_t                   dataOut2;
    logic                    issue_en;
    reg_addr_t               issue_target;
    label_t                  issue_label;

    modport slave (
        input  fu_valid, fu_label, fu_value,
        output fu_ready,
        output cdb_valid, cdb_label, cdb_value,
        input  readAddr1, readAddr2,
        output labelOut1, labelOut2, dataOut1, dataOut2,
        input  issue_en, issue_target, issue_label
    );

    modport master (
        output fu_valid, fu_label, fu_value,
        input  fu_ready,
        input  cdb_valid, cdb_label, cdb_value,
        output readAddr1, readAddr2,
        input  labelOut1, labelOut2, dataOut1, dataOut2,
        output issue_en, issue_target, issue_label
    );
endinterface

// File: rtl/cdb_writeback_rr_arbiter.sv
// cdb_writeback_rr_arbiter: N-wide round-robin arbiter with one-hot grant.
// Ports: clk, rst (async, active-high); i_req requests; o_gnt one-hot grant (zero while rst);
//   o_idx index of the granted requester; o_any a grant is issued this cycle.
// The search starts at the pointer and wraps; the pointer moves past the winner on every grant.
module cdb_writeback_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [IDX_W-1:0] r_ptr;
    logic [N-1:0]     w_gnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[(int'(r_ptr) + k) % N]) begin
                w_found                        = 1'b1;
                w_gnt[(int'(r_ptr) + k) % N]   = 1'b1;
                w_idx                          = IDX_W'((int'(r_ptr) + k) % N);
            end
        end
    end

    // Grants are masked during reset so no FU believes its result was taken.
    assign o_gnt = rst ? '0 : w_gnt;
    assign o_any = w_found && !rst;
    assign o_idx = w_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (w_found)
            r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
    end
endmodule

// File: rtl/cdb_writeback.sv
// cdb_writeback: Tomasulo writeback stage - arbitrates FU results onto the CDB and owns the
// register status file (32 values + producer labels).
// Ports: clk, rst (async, active-high); bus (cdb_writeback_if.slave) carrying FU results/grants,
//   the registered CDB broadcast, two combinational read ports and the issue label write.
// Optional feature: define CDB_BYPASS_EN to forward an in-flight CDB broadcast to the read ports.
module cdb_writeback
    import cdb_writeback_pkg::*;
#(
    parameter int N_FU = 4
) (
    input  logic            clk,
    input  logic            rst,
    cdb_writeback_if.slave  bus
);
    localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]  w_gnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    label_t           w_fu_label;
    data_t            w_fu_value;
    logic             w_byp1;
    logic             w_byp2;

    label_t r_lab [NUM_REGS];
    data_t  r_val [NUM_REGS];
    logic   r_cdb_valid;
    label_t r_cdb_label;
    data_t  r_cdb_value;

    cdb_writeback_rr_arbiter #(.N(N_FU), .IDX_W(IDX_W)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (bus.fu_valid),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_fu_label   = label_at((8*LABEL_W)'(bus.fu_label), int'(w_idx));
    assign w_fu_value   = value_at((8*DATA_W)'(bus.fu_value), int'(w_idx));
    assign bus.fu_ready = w_gnt;

    // A granted label-0 result is consumed without broadcasting; label/value keep the last real one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_label <= LABEL_NONE;
            r_cdb_value <= '0;
        end else if (w_any) begin
            r_cdb_valid <= w_fu_label != LABEL_NONE;
            if (w_fu_label != LABEL_NONE) begin
                r_cdb_label <= w_fu_label;
                r_cdb_value <= w_fu_value;
            end
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    // Register 0 is never written after reset. Issue is applied after the CDB capture so that
    // a same-edge issue to a capturing register keeps the new producer label.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_lab[r] <= LABEL_NONE;
                r_val[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (r_cdb_valid && r_lab[r] == r_cdb_label) begin
                    r_val[r] <= r_cdb_value;
                    r_lab[r] <= LABEL_NONE;
                end
                if (bus.issue_en && int'(bus.issue_target) == r)
                    r_lab[r] <= bus.issue_label;
            end
        end
    end

`ifdef CDB_BYPASS_EN
    assign w_byp1 = r_cdb_valid && r_cdb_label != LABEL_NONE && r_lab[bus.readAddr1] == r_cdb_label;
    assign w_byp2 = r_cdb_valid && r_cdb_label != LABEL_NONE && r_lab[bus.readAddr2] == r_cdb_label;
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign bus.labelOut1 = w_byp1 ? LABEL_NONE : r_lab[bus.readAddr1];
    assign bus.labelOut2 = w_byp2 ? LABEL_NONE : r_lab[bus.readAddr2];
    assign bus.dataOut1  = w_byp1 ? r_cdb_value : r_val[bus.readAddr1];
    assign bus.dataOut2  = w_byp2 ? r_cdb_value : r_val[bus.readAddr2];

    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_label = r_cdb_label;
    assign bus.cdb_value = r_cdb_value;
endmodule

// File: doc/cdb_writeback.md
Name: cdb_writeback

Overview:
- Writeback end of the Tomasulo issue path: arbitrates completed functional-unit (FU) results onto the Common Data Bus (CDB).
- Owns the register status file: 32 x 32-bit values plus a 4-bit producer label per register.
- Serves the issue stage's two read ports (label + value) and its label-write on issue.
- Clears pending labels when the matching CDB broadcast arrives.

Parameters:
- N_FU, 4, number of FU result requesters (2..8).
- LABEL_W, 4, label width; label 0 means "no pending producer".
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fu_valid  in  N_FU  per-FU result valid.
- fu_label  in  N_FU*LABEL_W  per-FU result label (packed, FU0 in LSBs).
- fu_value  in  N_FU*DATA_W  per-FU result value (packed).
- fu_ready  out  N_FU  one-hot grant; the result is accepted this cycle.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_label  out  LABEL_W  broadcast label.
- cdb_value  out  DATA_W  broadcast value.
- readAddr1  in  5  issue read address 1 (rs).
- readAddr2  in  5  issue read address 2 (rt).
- labelOut1  out  LABEL_W  pending label of readAddr1.
- labelOut2  out  LABEL_W  pending label of readAddr2.
- dataOut1  out  DATA_W  value of readAddr1.
- dataOut2  out  DATA_W  value of readAddr2.
- issue_en  in  1  issue writes a new producer label.
- issue_target  in  5  destination register.
- issue_label  in  LABEL_W  label of the issuing reservation station.

Behaviour:
- Reset (async, rst=1):
  - all register values 0, all labels 0.
  - cdb_valid=0, cdb_label=0, cdb_value=0.
  - round-robin pointer rr=0.
  - fu_ready=0 while rst is high.
- Arbitration (combinational):
  - Among fu_valid, grant the first set bit searching from index rr upward, wrapping modulo N_FU.
  - fu_ready is one-hot or zero.
  - An FU holds valid, label and value stable until it sees ready=1.
- On a clock edge with a grant to FU i:
  - cdb_valid<=1, cdb_label<=fu_label[i], cdb_value<=fu_value[i].
  - rr<=(i+1) mod N_FU.
  - Latency from acceptance to broadcast: 1 cycle.
- No grant: cdb_valid<=0, label and value hold, rr holds.
- A granted request with label 0 is consumed but suppressed: cdb_valid<=0, rr still advances.
- CDB capture (edge where cdb_valid=1): every register r with label[r]==cdb_label gets value[r]<=cdb_value and label[r]<=0. Multiple matches are all updated.
- Issue write (edge with issue_en=1 and issue_target!=0): label[issue_target]<=issue_label.
- Register 0: label and value are always 0; issue and CDB writes to it are ignored.
- Simultaneous issue and CDB capture on the same register: the value is written from the CDB; the label becomes issue_label, so issue wins.
- Reads are combinational from the current state (see the optional feature for the bypass).
- Mid-operation reset: an in-flight broadcast is lost; FUs must re-present their results after reset.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined: when cdb_valid=1 and label[readAddrX]==cdb_label (nonzero), the read returns labelOutX=0 and dataOutX=cdb_value in the same cycle.
- Not defined: reads see the capture one cycle later, from the register state.

Decomposition:
- Shared package (head.v defines):
  - LABEL_W, DATA_W, NUM_REGS=32.
  - LABEL_NONE=0.
  - packed-vector slice helpers.
- One natural sub-module: rr_arbiter (N_FU-wide round-robin, one-hot grant, pointer update on grant).

Test Plan:
1. Reset:
   - Stimulus: rst pulse mid-cycle.
   - Response: all outputs 0 immediately; readAddr1=5 returns label 0, data 0.
2. Issue then writeback:
   - Stimulus: issue_en, target=8, label=3; next cycle read r8; FU2 presents label 3, value 0xDEADBEEF.
   - Response: the read gives label 3. FU2 sees ready; the cycle after, cdb_valid=1 with label 3; the next read of r8 gives label 0, data 0xDEADBEEF.
3. Round-robin:
   - Stimulus: all four FUs valid continuously from reset.
   - Response: grants in order 0,1,2,3,0.
   - Stimulus: only FU1 and FU3 valid from rr=2.
   - Response: grant FU3 first, then FU1.
4. Multi-match:
   - Stimulus: r4 and r9 both labelled 5; broadcast label 5, value 0x11.
   - Response: both registers become 0x11 with label 0.
5. Collision:
   - Stimulus: same edge, CDB label 5 captures into r4 while issue writes r4 with label 7.
   - Response: r4 value=CDB value, label=7.
   - Stimulus: issue_target=0.
   - Response: r0 stays label 0, value 0.
6. Bypass:
   - Stimulus: with CDB_BYPASS_EN, read r4 (label 5) during cdb_valid with label 5, value 0x22.
   - Response: label 0, data 0x22 the same cycle; without the macro the same read returns label 5.
